// File: rtl/core_pkg.sv
// Shared core definitions: immediate-format select encoding and machine width.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

endpackage

// File: rtl/imm_extend_fmt.sv
// Combinational RV32I immediate format mux: gathers scattered instr bits per format.
module imm_extend_fmt
  import core_pkg::*;
(
  input  logic [31:7]     instr,
  input  logic [2:0]      immSrc,
  output logic [XLEN-1:0] immExt,
  output logic            illegal
);

  always_comb begin
    immExt  = '0;
    illegal = 1'b0;
    case (immSrc)
      IMM_I: immExt = {{20{instr[31]}}, instr[31:20]};
      IMM_S: immExt = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: immExt = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: immExt = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: immExt = {instr[31:12], 12'h000};
      // Unused encodings yield a clean zero so nothing downstream sees X.
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend.sv
// Decode-stage immediate generator: combinational ImmExt plus a registered copy
// and a sticky flag recording any unsupported ImmSrc.
module imm_extend
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [31:7]     instr,
  input  logic [2:0]      ImmSrc,
  output logic [XLEN-1:0] ImmExt,
  output logic [XLEN-1:0] ImmExtQ,
  output logic            ImmSrcBad
);

  logic illegal;

  imm_extend_fmt uFmt (
    .instr   (instr),
    .immSrc  (ImmSrc),
    .immExt  (ImmExt),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ImmExtQ   <= '0;
      ImmSrcBad <= 1'b0;
    end else begin
      ImmExtQ <= ImmExt;
      if (illegal) ImmSrcBad <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_extend.sv
// Scoreboard bench for imm_extend: directed spec vectors plus randomized traffic
// against an arithmetic reference model of the immediate formats.
module tb_imm_extend;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:7] instr = '0;
  logic [2:0]  ImmSrc = 3'b000;
  logic [31:0] ImmExt, ImmExtQ;
  logic        ImmSrcBad;

  int errors = 0;
  int checks = 0;

  string       combName[$];
  logic [31:0] combExp[$];
  logic [31:0] regExpQ[$];
  logic        regExpBad[$];
  logic        mdlBad = 1'b0;
  bit          done = 1'b0;

  imm_extend dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .ImmSrc    (ImmSrc),
    .ImmExt    (ImmExt),
    .ImmExtQ   (ImmExtQ),
    .ImmSrcBad (ImmSrcBad)
  );

  always #5 clk = ~clk;

  // Immediate value as a signed integer built from weighted fields, then wrapped to 32 bits.
  function automatic logic [31:0] refImm(input logic [31:0] w, input logic [2:0] s);
    longint v;
    v = 0;
    case (s)
      3'd0: v = longint'(w[31:20]) - (w[31] ? 64'sd4096 : 64'sd0);
      3'd1: v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - (w[31] ? 64'sd4096 : 64'sd0);
      3'd2: v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
              + longint'(w[11:8]) * 2 - (w[31] ? 64'sd8192 : 64'sd0);
      3'd3: v = longint'(w[31]) * (64'sd1 << 20) + longint'(w[19:12]) * 4096
              + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
              - (w[31] ? (64'sd1 << 21) : 64'sd0);
      3'd4: v = longint'(w[31:12]) * 4096;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic apply(input logic [31:0] w, input logic [2:0] s, input string nm,
                       input logic [31:0] exp);
    @(negedge clk);
    instr  = w[31:7];
    ImmSrc = s;
    #1;
    combName.push_back(nm);
    combExp.push_back(exp);
  endtask

  // Register model: what ImmExtQ/ImmSrcBad must hold after each rising edge.
  always @(posedge clk) begin
    logic [31:0] w;
    w = {instr, 7'b0};
    if (reset) begin
      mdlBad = 1'b0;
      regExpQ.push_back(32'h0);
    end else begin
      if (ImmSrc > 3'd4) mdlBad = 1'b1;
      regExpQ.push_back(refImm(w, ImmSrc));
    end
    regExpBad.push_back(mdlBad);
  end

  // Registered-output monitor.
  always @(posedge clk) begin
    logic [31:0] eq;
    logic        eb;
    #1;
    if (!done) begin
      if (regExpQ.size() == 0) begin
        errors++; checks++;
        $display("FAIL regq_missing: no expected entry at t=%0t", $time);
      end else begin
        eq = regExpQ.pop_front();
        eb = regExpBad.pop_front();
        checks++;
        if (ImmExtQ !== eq) begin
          errors++;
          $display("FAIL ImmExtQ t=%0t: got %h want %h", $time, ImmExtQ, eq);
        end
        checks++;
        if (ImmSrcBad !== eb) begin
          errors++;
          $display("FAIL ImmSrcBad t=%0t: got %b want %b", $time, ImmSrcBad, eb);
        end
      end
    end
  end

  // Combinational-output monitor.
  initial begin
    string       nm;
    logic [31:0] e;
    forever begin
      wait (combName.size() != 0);
      nm = combName.pop_front();
      e  = combExp.pop_front();
      checks++;
      if (ImmExt !== e) begin
        errors++;
        $display("FAIL %s: ImmExt got %h want %h", nm, ImmExt, e);
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [2:0]  s;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    apply(32'hFFF00093, 3'd0, "I_all_ones",  32'hFFFFFFFF);
    apply(32'h80000000, 3'd0, "I_sign_only", 32'hFFFFF800);
    apply(32'h00000F80, 3'd1, "S_low5",      32'h0000001F);
    apply(32'h80000000, 3'd1, "S_sign_only", 32'hFFFFF800);
    apply(32'h80000000, 3'd2, "B_sign_only", 32'hFFFFF000);
    apply(32'h00000080, 3'd2, "B_bit7",      32'h00000800);
    apply(32'h80000000, 3'd3, "J_sign_only", 32'hFFF00000);
    apply(32'h00100000, 3'd3, "J_bit20",     32'h00000800);
    apply(32'h12345000, 3'd4, "U_12345",     32'h12345000);
    apply(32'h80000000, 3'd4, "U_no_fill",   32'h80000000);

    // Illegal select, then flag must stick while legal traffic resumes.
    apply(32'hFFFFFFFF, 3'd5, "illegal_101", 32'h0);
    apply(32'hFFFFFFFF, 3'd7, "illegal_111", 32'h0);
    apply(32'h7FF00000, 3'd0, "I_after_bad", 32'h000007FF);
    apply(32'h00000000, 3'd0, "I_zero",      32'h0);
    @(negedge clk); reset = 1'b1;
    apply(32'hABCDE000, 3'd4, "U_in_reset",  32'hABCDE000);
    @(negedge clk); reset = 1'b0;

    for (int k = 0; k < 400; k++) begin
      w = $urandom;
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) reset = 1'b1;
      else reset = 1'b0;
      apply(w, s, "random", refImm(w, s));
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (combName.size() != 0) begin
      errors++;
      $display("FAIL comb_drain: %0d entries left, want 0", combName.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish by t=%0t", $time);
    $fatal(1);
  end

endmodule
